instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle sequencer for the 9-bit datapath. It owns the PC and steps each
//  instruction through FETCH/EXEC/[MEMW]/WB.
//  It gates the decoder's RegWrite/MemWrite so writes land in exactly one cycle.
//  Req/Ack handshake with the testbench/top level: start program, report halt.
// PARAMETERS
//  PCW       10         PC / branch target width (bits)
//  MCW       9          instruction width (bits)
//  HALT_CODE 9'h1FF     instruction encoding that stops the program
//  START_PC  0          PC loaded on Req
//  MEM_LAT   1          extra wait cycles for load data (1..15)
// PORTS
//  Clk        in   1    clock, rising edge
//  Reset      in   1    asynchronous, active-high reset
//  Req        in   1    start request, sampled only in IDLE
//  Instr      in   MCW  instruction ROM output for address PC (combinational ROM)
//  RegWrite_d in   1    decoder RegWrite for current instruction
//  MemWrite_d in   1    decoder MemWrite
//  MemtoReg_d in   1    decoder MemtoReg (load)
//  Branch_d   in   1    decoder Branch (bne)
//  Zero       in   1    ALU zero flag; bne taken when Branch_d && !Zero
//  Target     in   PCW  branch target from lookup/datapath
//  PC         out  PCW  program counter to instruction ROM
//  IRLoad     out  1    capture Instr into instruction register
//  RegWE      out  1    gated register-file write enable
//  MemWE      out  1    gated data-memory write enable
//  Busy       out  1    high in every state except IDLE
//  Ack        out  1    one-cycle pulse: program halted
//  CycleCnt   out  16   cycles since Req (only with CYCLE_COUNT_EN)
// BEHAVIOUR
//  Reset (async): state=IDLE, PC=0, IRLoad=RegWE=MemWE=Busy=Ack=0, wait cnt=0.
//  Reset mid-instruction aborts it; no write enable may glitch high.
//  States:
//  - IDLE: Req=1 -> PC<=START_PC, go FETCH. Req=0 -> stay.
//  - FETCH: IRLoad=1 for this one cycle, then go EXEC.
//  - EXEC: Instr==HALT_CODE -> HALT. Else MemtoReg_d -> MEMW with wait=MEM_LAT.
//    Otherwise -> WB.
//  - MEMW: decrement wait; go WB in the cycle wait reaches 1.
//  - WB: RegWE=RegWrite_d, MemWE=MemWrite_d, both for this single cycle.
//    PC <= (Branch_d && !Zero) ? Target : PC+1. Then go FETCH.
//  - HALT: Ack=1 for one cycle, PC holds, then go IDLE.
//  Outputs are registered from state; RegWE/MemWE are 0 outside WB, always.
//  Latency: 3 cycles per non-load instruction; 3+MEM_LAT per load.
//  Halt costs FETCH+EXEC+HALT, so Ack rises 3 cycles after the halt fetch.
//  PC+1 wraps modulo 2^PCW (all-ones -> 0), no error.
//  Target is taken verbatim; Zero and Target are sampled in WB only.
//  Req while Busy is ignored. Req high in the HALT->IDLE cycle is ignored.
//  A restart needs Req sampled high in IDLE.
//  Decoder inputs are X-tolerant outside EXEC/WB; never propagate X to RegWE/MemWE.
//  Treat X as 0 in IDLE.
// CONFIGURATION
//  CYCLE_COUNT_EN defined: CycleCnt clears on Req accept and +1 each Busy cycle.
//  It saturates at 16'hFFFF and holds its value through IDLE until the next Req.
//  CYCLE_COUNT_EN undefined: CycleCnt port and counter are absent; no other change.
// TESTING
//  T1 Reset mid-WB, RegWrite_d=1 -> RegWE=0 same cycle; state IDLE; PC=0.
//  T2 Req; ROM {add, xor, HALT} -> IRLoad at cycles 1,4,7; RegWE at 3,6.
//     Ack pulses at cycle 9; Busy falls at cycle 10.
//  T3 Load with MEM_LAT=3: WB 6 cycles after FETCH; RegWE=1 one cycle.
//     Store: MemWE=1 one cycle, RegWE=0.
//  T4 bne, Zero=0, Target=10'h05A -> next PC=0x05A.
//     Same with Zero=1 -> PC+1; RegWE=MemWE=0 in both cases.
//  T5 PC=10'h3FF non-branch -> next PC=0. Req pulsed while Busy -> no PC reload.
//  T6 CYCLE_COUNT_EN, 3-instr program+halt -> CycleCnt=9 at Ack.
//     Value holds in IDLE; clears on the next Req.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Control bundle between the instruction sequencer and its top level.
// CycleCnt is present only when CYCLE_COUNT_EN is defined.
interface instr_sequencer_if #(
    parameter int PCW = 10,
    parameter int MCW = 9
);
    logic           Req;
    logic [MCW-1:0] Instr;
    logic           RegWrite_d;
    logic           MemWrite_d;
    logic           MemtoReg_d;
    logic           Branch_d;
    logic           Zero;
    logic [PCW-1:0] Target;
    logic [PCW-1:0] PC;
    logic           IRLoad;
    logic           RegWE;
    logic           MemWE;
    logic           Busy;
    logic           Ack;
`ifdef CYCLE_COUNT_EN
    logic [15:0]    CycleCnt;

    modport master (
        output Req, Instr, RegWrite_d, MemWrite_d,
        output MemtoReg_d, Branch_d, Zero, Target,
        input  PC, IRLoad, RegWE, MemWE, Busy, Ack,
        input  CycleCnt
    );

    modport slave (
        input  Req, Instr, RegWrite_d, MemWrite_d,
        input  MemtoReg_d, Branch_d, Zero, Target,
        output PC, IRLoad, RegWE, MemWE, Busy, Ack,
        output CycleCnt
    );
`else
    modport master (
        output Req, Instr, RegWrite_d, MemWrite_d,
        output MemtoReg_d, Branch_d, Zero, Target,
        input  PC, IRLoad, RegWE, MemWE, Busy, Ack
    );

    modport slave (
        input  Req, Instr, RegWrite_d, MemWrite_d,
        input  MemtoReg_d, Branch_d, Zero, Target,
        output PC, IRLoad, RegWE, MemWE, Busy, Ack
    );
`endif
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/EXEC/MEMW/WB sequencer; owns the PC, gates decoder writes.
// Optional: define CYCLE_COUNT_EN for the 16-bit CycleCnt output.
module instr_sequencer #(
    parameter int             PCW       = 10,
    parameter int             MCW       = 9,
    parameter logic [MCW-1:0] HALT_CODE = 9'h1FF,
    parameter logic [PCW-1:0] START_PC  = '0,
    parameter int             MEM_LAT   = 1
) (
    input logic              Clk,
    input logic              Reset,
    instr_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEMW,
        S_WB,
        S_HALT
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_wait;
    logic [3:0]     w_wait_nxt;
    logic [PCW-1:0] r_pc;
    logic [PCW-1:0] w_pc_nxt;
    logic           w_taken;
    logic           r_irload;
    logic           r_regwe;
    logic           r_memwe;
    logic           r_busy;
    logic           r_ack;

    assign w_taken = bus.Branch_d && !bus.Zero;

    // Next state, load-wait counter and PC update.
    always_comb begin
        w_next     = r_state;
        w_wait_nxt = r_wait;
        w_pc_nxt   = r_pc;
        unique case (r_state)
            S_IDLE: begin
                if (bus.Req == 1'b1) begin
                    w_next   = S_FETCH;
                    w_pc_nxt = START_PC;
                end
            end
            S_FETCH: begin
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (bus.Instr == HALT_CODE) begin
                    w_next = S_HALT;
                end else if (bus.MemtoReg_d == 1'b1) begin
                    w_next     = S_MEMW;
                    w_wait_nxt = 4'(MEM_LAT);
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEMW: begin
                w_wait_nxt = r_wait - 4'd1;
                if (r_wait <= 4'd1) begin
                    w_next     = S_WB;
                    w_wait_nxt = '0;
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                // PC+1 wraps naturally at the PC width
                w_pc_nxt = w_taken ? bus.Target : r_pc + PCW'(1);
            end
            S_HALT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, PC and wait counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Outputs registered from the next state so they are glitch-free;
    // decoder lines are stable from EXEC since Instr only follows PC.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_irload <= 1'b0;
            r_regwe  <= 1'b0;
            r_memwe  <= 1'b0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_irload <= (w_next == S_FETCH);
            r_regwe  <= (w_next == S_WB) && (bus.RegWrite_d == 1'b1);
            r_memwe  <= (w_next == S_WB) && (bus.MemWrite_d == 1'b1);
            r_busy   <= (w_next != S_IDLE);
            r_ack    <= (w_next == S_HALT);
        end
    end

    assign bus.PC     = r_pc;
    assign bus.IRLoad = r_irload;
    assign bus.RegWE  = r_regwe;
    assign bus.MemWE  = r_memwe;
    assign bus.Busy   = r_busy;
    assign bus.Ack    = r_ack;

`ifdef CYCLE_COUNT_EN
    logic [15:0] r_cnt;

    // Busy-cycle counter; the accept edge clears it and counts FETCH.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && w_next == S_FETCH) begin
            r_cnt <= 16'd1;
        end else if (w_next != S_IDLE && r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign bus.CycleCnt = r_cnt;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed programs, event queue.
// CycleCnt checks compile only with CYCLE_COUNT_EN.
module tb_instr_sequencer;

    localparam int PCW = 10;
    localparam int MCW = 9;
    localparam int LAT = 3;

    localparam logic [8:0] I_ADD  = 9'h000;
    localparam logic [8:0] I_XOR  = 9'h040;
    localparam logic [8:0] I_LW   = 9'h080;
    localparam logic [8:0] I_SW   = 9'h0C0;
    localparam logic [8:0] I_BNE  = 9'h100;
    localparam logic [8:0] I_HALT = 9'h1FF;

    // kinds: 0 IRLoad, 1 RegWE, 2 MemWE, 3 Ack
    typedef struct {
        int         kind;
        logic [9:0] pc;
        int         cyc;
    } ev_t;

    logic Clk = 1'b0;
    logic Reset;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   base = 0;
    ev_t  q[$];

    logic [8:0] rom [0:1023];
    logic       zt  [0:1023];
    logic [9:0] tg  [0:1023];
    logic [2:0] op;

    always #5 Clk = ~Clk;

    instr_sequencer_if #(.PCW(PCW), .MCW(MCW)) bus ();

    instr_sequencer #(
        .PCW(PCW),
        .MCW(MCW),
        .HALT_CODE(9'h1FF),
        .START_PC(10'd0),
        .MEM_LAT(LAT)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    assign bus.Instr      = rom[bus.PC];
    assign op             = bus.Instr[8:6];
    assign bus.RegWrite_d = (op == 3'd0) || (op == 3'd1) || (op == 3'd2);
    assign bus.MemWrite_d = (op == 3'd3);
    assign bus.MemtoReg_d = (op == 3'd2);
    assign bus.Branch_d   = (op == 3'd4);
    assign bus.Zero       = zt[bus.PC];
    assign bus.Target     = tg[bus.PC];

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic push(input int k, input logic [9:0] p, input int c);
        ev_t e;
        e.kind = k;
        e.pc   = p;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    // Monitor: every asserted event output pops one expected entry.
    always @(negedge Clk) begin : mon
        logic [3:0] s;
        ev_t        e;
        s = {bus.Ack, bus.MemWE, bus.RegWE, bus.IRLoad};
        if (Reset !== 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k] !== 1'b0) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL sb_unexpected: got kind %0d pc %h cyc %0d, required none",
                                 k, bus.PC, cyc - base);
                    end else begin
                        e = q.pop_front();
                        if (e.kind != k || e.pc !== bus.PC || e.cyc != cyc - base) begin
                            fails++;
                            $display("FAIL sb_event: got kind %0d pc %h cyc %0d, required kind %0d pc %h cyc %0d",
                                     k, bus.PC, cyc - base, e.kind, e.pc, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic start();
        @(negedge Clk);
        bus.Req = 1'b1;
        base = cyc;
        @(negedge Clk);
        bus.Req = 1'b0;
    endtask

    task automatic wait_ack(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (bus.Ack === 1'b1) begin
                at = cyc - base;
                break;
            end
        end
        if (at < 0) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got no Ack, required Ack within 200 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish by 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int at;
        for (int i = 0; i < 1024; i++) begin
            rom[i] = I_HALT;
            zt[i]  = 1'b1;
            tg[i]  = '0;
        end
        bus.Req = 1'b0;
        Reset   = 1'b0;
        #2 Reset = 1'b1;
        #1;
        chk("rst_pc", bus.PC, 0);
        chk("rst_irload", bus.IRLoad, 0);
        chk("rst_regwe", bus.RegWE, 0);
        chk("rst_memwe", bus.MemWE, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_ack", bus.Ack, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("idle_busy", bus.Busy, 0);

        // {add, xor, HALT}
        rom[0] = I_ADD;
        rom[1] = I_XOR;
        rom[2] = I_HALT;
        push(0, 10'h000, 1);
        push(1, 10'h000, 3);
        push(0, 10'h001, 4);
        push(1, 10'h001, 6);
        push(0, 10'h002, 7);
        push(3, 10'h002, 9);
        start();
        wait_ack(at);
        chk("t2_ack_cycle", at, 9);
        chk("t2_busy_at_ack", bus.Busy, 1);
`ifdef CYCLE_COUNT_EN
        chk("t6_cnt_at_ack", bus.CycleCnt, 9);
`endif
        bus.Req = 1'b1;
        @(negedge Clk);
        bus.Req = 1'b0;
        chk("t2_busy_fall", bus.Busy, 0);
        @(negedge Clk);
        chk("t2_req_in_halt_ignored", bus.Busy, 0);
        chk("t2_pc_hold", bus.PC, 10'h002);
`ifdef CYCLE_COUNT_EN
        chk("t6_cnt_hold", bus.CycleCnt, 9);
`endif

        // load, store, bne taken, bne not taken, HALT
        rom[0]     = I_LW;
        rom[1]     = I_SW;
        rom[2]     = I_BNE;
        zt[2]      = 1'b0;
        tg[2]      = 10'h05A;
        rom[10'h05A] = I_BNE;
        zt[10'h05A]  = 1'b1;
        tg[10'h05A]  = 10'h123;
        rom[10'h05B] = I_HALT;
        push(0, 10'h000, 1);
        push(1, 10'h000, 6);
        push(0, 10'h001, 7);
        push(2, 10'h001, 9);
        push(0, 10'h002, 10);
        push(0, 10'h05A, 13);
        push(0, 10'h05B, 16);
        push(3, 10'h05B, 18);
        start();
`ifdef CYCLE_COUNT_EN
        chk("t6_cnt_clear", bus.CycleCnt, 1);
`endif
        repeat (7) @(negedge Clk);
        bus.Req = 1'b1;
        @(negedge Clk);
        bus.Req = 1'b0;
        wait_ack(at);
        chk("t3_ack_cycle", at, 18);
        repeat (2) @(negedge Clk);

        // bne to 3FF, add at 3FF wraps to 0; reset mid-WB
        rom[0]       = I_BNE;
        zt[0]        = 1'b0;
        tg[0]        = 10'h3FF;
        rom[10'h3FF] = I_ADD;
        push(0, 10'h000, 1);
        push(0, 10'h3FF, 4);
        push(1, 10'h3FF, 6);
        push(0, 10'h000, 7);
        push(0, 10'h3FF, 10);
        push(1, 10'h3FF, 12);
        start();
        repeat (11) @(negedge Clk);
        chk("t1_regwe_in_wb", bus.RegWE, 1);
        #1 Reset = 1'b1;
        #1;
        chk("t1_regwe_reset", bus.RegWE, 0);
        chk("t1_memwe_reset", bus.MemWE, 0);
        chk("t1_busy_reset", bus.Busy, 0);
        chk("t1_pc_reset", bus.PC, 0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        chk("t1_stays_idle", bus.Busy, 0);
        chk("t1_pc_idle", bus.PC, 0);
        chk("sb_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
